// File: rtl/if_fetch_stage_pkg.sv
// ---------------------------------------------------------------------------
// if_fetch_stage_pkg
// Shared definitions for the instruction-fetch stage and the decode stage:
// datapath widths, reset/opcode-field defaults, the fetch FSM encoding,
// the opcode constants decode compares against, and a word-align helper.
// ---------------------------------------------------------------------------
package if_fetch_stage_pkg;

  localparam int XLEN  = 32;
  localparam int ILEN  = 32;
  localparam int OPC_W = 5;

  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam int              OPC_LSB_DEFAULT  = 27;

  // Opcode values carried in instr[OPC_LSB+4:OPC_LSB]
  localparam logic [OPC_W-1:0] OPC_AND = 5'h00;
  localparam logic [OPC_W-1:0] OPC_OR  = 5'h01;
  localparam logic [OPC_W-1:0] OPC_ADD = 5'h02;
  localparam logic [OPC_W-1:0] OPC_SUB = 5'h06;
  localparam logic [OPC_W-1:0] OPC_SLT = 5'h07;
  localparam logic [OPC_W-1:0] OPC_LW  = 5'h08;
  localparam logic [OPC_W-1:0] OPC_SW  = 5'h0A;
  localparam logic [OPC_W-1:0] OPC_BNE = 5'h0E;

  typedef enum logic [1:0] {
    ST_BOOT    = 2'd0,
    ST_FETCH   = 2'd1,
    ST_HOLD    = 2'd2,
    ST_DISCARD = 2'd3
  } fetch_state_t;

  // Fetch addresses are always word aligned; low two bits are dropped.
  function automatic logic [XLEN-1:0] align_word(input logic [XLEN-1:0] addr);
    return {addr[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/if_id_reg.sv
// ---------------------------------------------------------------------------
// if_id_reg
// IF/ID pipeline register. Flush kills the live flag, load captures a new
// instruction with its address and address+4, otherwise everything holds.
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   load, flush          capture a new instruction / invalidate (flush wins)
//   load_instr, load_pc  instruction and its address to capture
//   valid, instr, pc, pc4  registered contents
// ---------------------------------------------------------------------------
module if_id_reg
  import if_fetch_stage_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            load,
  input  logic            flush,
  input  logic [ILEN-1:0] load_instr,
  input  logic [XLEN-1:0] load_pc,
  output logic            valid,
  output logic [ILEN-1:0] instr,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] pc4
);

  // A flush only clears the live flag; the stale payload is harmless
  // because downstream qualifies everything with valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= 1'b0;
      instr <= '0;
      pc    <= '0;
      pc4   <= '0;
    end else if (flush) begin
      valid <= 1'b0;
    end else if (load) begin
      valid <= 1'b1;
      instr <= load_instr;
      pc    <= load_pc;
      pc4   <= load_pc + 32'd4;
    end
  end

endmodule

// File: rtl/if_fetch_stage.sv
// ---------------------------------------------------------------------------
// if_fetch_stage
// Instruction fetch: issues one request at a time to instruction memory,
// fills the IF/ID register, parks a returned instruction in a one-entry
// skid buffer while decode stalls, and handles branch redirects, including
// discarding a request that was already in flight.
// Ports:
//   clk, rst_n                     clock, asynchronous active-low reset
//   imem_req, imem_addr            fetch request and word-aligned address
//   imem_ack, imem_rdata           response strobe and instruction
//   stall                          decode cannot accept this cycle
//   branch_taken, branch_target    redirect request and its address
//   if_id_valid/instr/pc/pc4       IF/ID register contents
//   if_id_opcode                   opcode field of if_id_instr
// ---------------------------------------------------------------------------
module if_fetch_stage
  import if_fetch_stage_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int              OPC_LSB  = OPC_LSB_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  output logic             imem_req,
  output logic [XLEN-1:0]  imem_addr,
  input  logic             imem_ack,
  input  logic [ILEN-1:0]  imem_rdata,
  input  logic             stall,
  input  logic             branch_taken,
  input  logic [XLEN-1:0]  branch_target,
  output logic             if_id_valid,
  output logic [ILEN-1:0]  if_id_instr,
  output logic [XLEN-1:0]  if_id_pc,
  output logic [XLEN-1:0]  if_id_pc4,
  output logic [OPC_W-1:0] if_id_opcode
);

  fetch_state_t    state, state_next;
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] discard_addr;
  logic [ILEN-1:0] skid_instr;
  logic [XLEN-1:0] skid_pc;
  logic            skid_valid;

  logic            id_load;
  logic            id_flush;
  logic [ILEN-1:0] id_instr;
  logic [XLEN-1:0] id_pc;
  logic            skid_capture;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_BOOT;
    else        state <= state_next;
  end

  // A redirect without a response leaves a request in flight, so it must
  // be drained in DISCARD before a request to the target can be issued.
  always_comb begin
    state_next = state;
    case (state)
      ST_BOOT:    state_next = ST_FETCH;
      ST_FETCH: begin
        if (branch_taken)  state_next = imem_ack ? ST_FETCH : ST_DISCARD;
        else if (imem_ack) state_next = stall ? ST_HOLD : ST_FETCH;
      end
      ST_HOLD: begin
        if (branch_taken || !stall) state_next = ST_FETCH;
      end
      ST_DISCARD: begin
        if (imem_ack) state_next = ST_FETCH;
      end
      default:    state_next = ST_BOOT;
    endcase
  end

  // DISCARD keeps presenting the abandoned address while pc already
  // tracks the newest target. Anything not loaded while decode is free
  // becomes a bubble; a redirect always kills the IF/ID contents.
  always_comb begin
    imem_req     = 1'b0;
    imem_addr    = align_word(pc);
    id_load      = 1'b0;
    id_instr     = imem_rdata;
    id_pc        = pc;
    skid_capture = 1'b0;
    case (state)
      ST_FETCH: begin
        imem_req     = 1'b1;
        id_load      = imem_ack && !stall && !branch_taken;
        skid_capture = imem_ack && stall && !branch_taken;
      end
      ST_HOLD: begin
        id_load  = !stall && !branch_taken && skid_valid;
        id_instr = skid_instr;
        id_pc    = skid_pc;
      end
      ST_DISCARD: begin
        imem_req  = 1'b1;
        imem_addr = discard_addr;
      end
      default: ;
    endcase
    id_flush = branch_taken || (!id_load && !stall);
  end

  // pc is not advanced when the skid buffer is filled, so it still names
  // the parked instruction and advances when that instruction moves on.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc           <= align_word(RESET_PC);
      discard_addr <= '0;
      skid_instr   <= '0;
      skid_pc      <= '0;
      skid_valid   <= 1'b0;
    end else begin
      if (state == ST_FETCH && branch_taken && !imem_ack)
        discard_addr <= align_word(pc);
      if (branch_taken) begin
        pc         <= align_word(branch_target);
        skid_valid <= 1'b0;
      end else begin
        if (id_load) begin
          pc         <= pc + 32'd4;
          skid_valid <= 1'b0;
        end
        if (skid_capture) begin
          skid_instr <= imem_rdata;
          skid_pc    <= pc;
          skid_valid <= 1'b1;
        end
      end
    end
  end

  if_id_reg u_if_id_reg (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (id_load),
    .flush      (id_flush),
    .load_instr (id_instr),
    .load_pc    (id_pc),
    .valid      (if_id_valid),
    .instr      (if_id_instr),
    .pc         (if_id_pc),
    .pc4        (if_id_pc4)
  );

  assign if_id_opcode = if_id_instr[OPC_LSB +: OPC_W];

endmodule

// File: tb/tb_if_fetch_stage.sv
// ---------------------------------------------------------------------------
// tb_if_fetch_stage
// Directed bench for if_fetch_stage. A default instance walks through
// sequential fetch, a stall into HOLD, a redirect through DISCARD, a
// redirect colliding with stall and ack, and a reset pulse during HOLD.
// A second instance with RESET_PC near the top of memory, acked every
// cycle, shows the address wrapping through zero.
// ---------------------------------------------------------------------------
module tb_if_fetch_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        stall;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        if_id_valid;
  logic [31:0] if_id_instr;
  logic [31:0] if_id_pc;
  logic [31:0] if_id_pc4;
  logic [4:0]  if_id_opcode;

  logic        imem_req_w;
  logic [31:0] imem_addr_w;
  logic        if_id_valid_w;
  logic [31:0] if_id_instr_w;
  logic [31:0] if_id_pc_w;
  logic [31:0] if_id_pc4_w;
  logic [4:0]  if_id_opcode_w;
  logic        imem_ack_w   = 1'b1;
  logic [31:0] imem_rdata_w = 32'h0000_0000;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  if_fetch_stage dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_ack      (imem_ack),
    .imem_rdata    (imem_rdata),
    .stall         (stall),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .if_id_valid   (if_id_valid),
    .if_id_instr   (if_id_instr),
    .if_id_pc      (if_id_pc),
    .if_id_pc4     (if_id_pc4),
    .if_id_opcode  (if_id_opcode)
  );

  if_fetch_stage #(.RESET_PC(32'hFFFF_FFF8)) dut_wrap (
    .clk           (clk),
    .rst_n         (rst_n),
    .imem_req      (imem_req_w),
    .imem_addr     (imem_addr_w),
    .imem_ack      (imem_ack_w),
    .imem_rdata    (imem_rdata_w),
    .stall         (stall),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .if_id_valid   (if_id_valid_w),
    .if_id_instr   (if_id_instr_w),
    .if_id_pc      (if_id_pc_w),
    .if_id_pc4     (if_id_pc4_w),
    .if_id_opcode  (if_id_opcode_w)
  );

  // Advance to just after the next rising edge.
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic ack, input logic [31:0] rdata,
                               input logic stl, input logic br,
                               input logic [31:0] target);
    imem_ack      = ack;
    imem_rdata    = rdata;
    stall         = stl;
    branch_taken  = br;
    branch_target = target;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%h expected=%h", tag, actual, expected);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    tick;
    tick;
    checkOutput("rst_req",   {31'd0, imem_req},    32'd0);
    checkOutput("rst_valid", {31'd0, if_id_valid}, 32'd0);
    checkOutput("rst_instr", if_id_instr,          32'd0);
    checkOutput("rst_pc",    if_id_pc,             32'd0);
    checkOutput("rst_pc4",   if_id_pc4,            32'd0);

    rst_n = 1'b1;
    #1;
    checkOutput("boot_req", {31'd0, imem_req}, 32'd0);

    // E1: BOOT -> FETCH
    tick;
    checkOutput("e1_req",      {31'd0, imem_req}, 32'd1);
    checkOutput("e1_addr",     imem_addr,         32'h0000_0000);
    checkOutput("wrap_addr0",  imem_addr_w,       32'hFFFF_FFF8);
    applyStimulus(1'b1, imem_addr, 1'b0, 1'b0, 32'h0);

    // E2: ack for 0
    tick;
    checkOutput("e2_valid",   {31'd0, if_id_valid}, 32'd1);
    checkOutput("e2_pc",      if_id_pc,             32'h0000_0000);
    checkOutput("e2_pc4",     if_id_pc4,            32'h0000_0004);
    checkOutput("e2_addr",    imem_addr,            32'h0000_0004);
    checkOutput("wrap_addr1", imem_addr_w,          32'hFFFF_FFFC);
    applyStimulus(1'b1, imem_addr, 1'b0, 1'b0, 32'h0);

    // E3: ack for 4
    tick;
    checkOutput("e3_pc",      if_id_pc,    32'h0000_0004);
    checkOutput("e3_addr",    imem_addr,   32'h0000_0008);
    checkOutput("wrap_addr2", imem_addr_w, 32'h0000_0000);
    checkOutput("wrap_pc",    if_id_pc_w,  32'hFFFF_FFFC);
    checkOutput("wrap_pc4",   if_id_pc4_w, 32'h0000_0000);
    applyStimulus(1'b1, imem_addr, 1'b1, 1'b0, 32'h0);

    // E4..E6: ack for 8 under stall, then HOLD with stray acks ignored
    for (int i = 0; i < 3; i++) begin
      tick;
      checkOutput("hold_req",   {31'd0, imem_req},    32'd0);
      checkOutput("hold_valid", {31'd0, if_id_valid}, 32'd1);
      checkOutput("hold_pc",    if_id_pc,             32'h0000_0004);
      applyStimulus(1'b1, 32'hDEAD_BEEF, (i < 2), 1'b0, 32'h0);
    end

    // E7: stall released, skid moves into IF/ID
    tick;
    checkOutput("unskid_pc",    if_id_pc,             32'h0000_0008);
    checkOutput("unskid_instr", if_id_instr,          32'h0000_0008);
    checkOutput("unskid_valid", {31'd0, if_id_valid}, 32'd1);
    checkOutput("unskid_req",   {31'd0, imem_req},    32'd1);
    checkOutput("unskid_addr",  imem_addr,            32'h0000_000C);
    applyStimulus(1'b1, 32'h7000_0000, 1'b0, 1'b0, 32'h0);

    // E8: instruction carrying a BNE opcode
    tick;
    checkOutput("e8_pc",     if_id_pc,             32'h0000_000C);
    checkOutput("e8_opcode", {27'd0, if_id_opcode}, 32'h0000_000E);
    checkOutput("e8_addr",   imem_addr,            32'h0000_0010);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b1, 32'h0000_0103);

    // E9, E10: redirect with request to 0x10 still outstanding
    tick;
    checkOutput("disc_req",   {31'd0, imem_req},    32'd1);
    checkOutput("disc_addr",  imem_addr,            32'h0000_0010);
    checkOutput("disc_valid", {31'd0, if_id_valid}, 32'd0);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    tick;
    checkOutput("disc_addr2",  imem_addr,            32'h0000_0010);
    checkOutput("disc_valid2", {31'd0, if_id_valid}, 32'd0);
    applyStimulus(1'b1, 32'hFFFF_FFFF, 1'b0, 1'b0, 32'h0);

    // E11: stale response dropped, fetch resumes at aligned target
    tick;
    checkOutput("drop_valid", {31'd0, if_id_valid}, 32'd0);
    checkOutput("drop_addr",  imem_addr,            32'h0000_0100);
    checkOutput("drop_req",   {31'd0, imem_req},    32'd1);
    applyStimulus(1'b1, 32'h1000_0100, 1'b1, 1'b1, 32'h0000_0200);

    // E12: redirect together with stall and ack
    tick;
    checkOutput("bsa_valid", {31'd0, if_id_valid}, 32'd0);
    checkOutput("bsa_addr",  imem_addr,            32'h0000_0200);
    applyStimulus(1'b1, 32'h4000_0200, 1'b1, 1'b0, 32'h0);

    // E13: into HOLD, then reset pulse
    tick;
    checkOutput("e13_req", {31'd0, imem_req}, 32'd0);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    rst_n = 1'b0;
    #1;
    checkOutput("arst_req",   {31'd0, imem_req},    32'd0);
    checkOutput("arst_valid", {31'd0, if_id_valid}, 32'd0);
    checkOutput("arst_instr", if_id_instr,          32'd0);
    checkOutput("arst_pc",    if_id_pc,             32'd0);
    checkOutput("arst_pc4",   if_id_pc4,            32'd0);
    checkOutput("arst_addr",  imem_addr,            32'd0);
    tick;
    rst_n = 1'b1;
    #1;
    checkOutput("reboot_req", {31'd0, imem_req}, 32'd0);
    tick;
    checkOutput("refetch_req",  {31'd0, imem_req}, 32'd1);
    checkOutput("refetch_addr", imem_addr,         32'h0000_0000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
